encoder_serializer_core: RTL and testbench

ENCODER_SERIALIZER_CORE -- requirements
Module: encoder_serializer

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/encoder_serializer_core_if.sv | 10 +
 rtl/tmds_encoder.sv | 73 +++++++
 rtl/encoder_serializer_core.sv | 46 ++++
 tb/tb_encoder_serializer_core.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, bit-counter terminal value, popcount helper.
package tmds_pkg;

  localparam logic [3:0] BIT_LAST = 4'd9;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {CTL_00 = 2'b00, CTL_01 = 2'b01, CTL_10 = 2'b10, CTL_11 = 2'b11} ctl_e;

  typedef struct packed {
    logic [9:0] word;
    logic [4:0] cnt;
  } enc_out_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/encoder_serializer_core_if.sv
// Pixel-side inputs and serial output of the TMDS encoder/serializer.
interface encoder_serializer_core_if;
  logic [7:0] pixelComponent;
  logic [1:0] controlBus;
  logic       DE;
  logic       tmdsSerialOut;

  modport master (output pixelComponent, controlBus, DE, input tmdsSerialOut);
  modport slave  (input pixelComponent, controlBus, DE, output tmdsSerialOut);
endinterface

// File: rtl/tmds_encoder.sv
// Combinational DVI TMDS encoder: transition minimisation, DC balance, control-token mux.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  input  logic [4:0] i_cnt,
  output logic [9:0] o_word,
  output logic [4:0] o_cnt
);

  logic [3:0] w_n1;
  logic [3:0] w_n1q;
  logic       w_xnor;
  logic [8:0] w_qm;
  logic [4:0] w_diff;
  logic [4:0] w_qm8x2;
  logic [4:0] w_nqm8x2;
  logic       w_cnt_zero;
  logic       w_cnt_pos;
  logic       w_cnt_neg;
  logic       w_bal;
  enc_out_t   w_out;

  always_comb begin
    w_n1    = ones8(i_data);
    w_xnor  = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);
    w_qm    = '0;
    w_qm[0] = i_data[0];
    for (int i = 1; i < 8; i++)
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
    w_qm[8] = ~w_xnor;
  end

  // cnt arithmetic is mod-32 two's complement; sign comes from bit 4
  always_comb begin
    w_n1q      = ones8(w_qm[7:0]);
    w_diff     = {w_n1q, 1'b0} - 5'd8;
    w_qm8x2    = {3'b000, w_qm[8], 1'b0};
    w_nqm8x2   = {3'b000, ~w_qm[8], 1'b0};
    w_cnt_zero = (i_cnt == 5'd0);
    w_cnt_neg  = i_cnt[4];
    w_cnt_pos  = !i_cnt[4] && !w_cnt_zero;
    w_bal      = (w_n1q == 4'd4);
  end

  always_comb begin
    w_out = '0;
    if (!i_de) begin
      unique case (ctl_e'(i_ctrl))
        CTL_00: w_out.word = TOK_C00;
        CTL_01: w_out.word = TOK_C01;
        CTL_10: w_out.word = TOK_C10;
        CTL_11: w_out.word = TOK_C11;
      endcase
      w_out.cnt = 5'd0;
    end else if (w_cnt_zero || w_bal) begin
      w_out.word = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
      w_out.cnt  = w_qm[8] ? (i_cnt + w_diff) : (i_cnt - w_diff);
    end else if ((w_cnt_pos && (w_n1q > 4'd4)) || (w_cnt_neg && (w_n1q < 4'd4))) begin
      w_out.word = {1'b1, w_qm[8], ~w_qm[7:0]};
      w_out.cnt  = i_cnt + w_qm8x2 - w_diff;
    end else begin
      w_out.word = {1'b0, w_qm[8], w_qm[7:0]};
      w_out.cnt  = i_cnt - w_nqm8x2 + w_diff;
    end
  end

  assign o_word = w_out.word;
  assign o_cnt  = w_out.cnt;

endmodule

// File: rtl/encoder_serializer_core.sv
// Bit-rate TMDS serializer: mod-10 counter strobes a load of the encoded word, then shifts LSB first.
module encoder_serializer_core
  import tmds_pkg::*;
(
  input  logic                       pixelClock,
  input  logic                       nReset,
  encoder_serializer_core_if.slave   bus
);

  logic [3:0] r_bitcnt;
  logic [9:0] r_shift;
  logic [4:0] r_cnt;
  logic [9:0] w_word;
  logic [4:0] w_cnt_next;
  logic       w_load;

  assign w_load = (r_bitcnt == BIT_LAST);

  tmds_encoder u_enc (
    .i_data (bus.pixelComponent),
    .i_ctrl (bus.controlBus),
    .i_de   (bus.DE),
    .i_cnt  (r_cnt),
    .o_word (w_word),
    .o_cnt  (w_cnt_next)
  );

  // Disparity only advances on the pixel-rate load edge
  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_bitcnt <= '0;
      r_shift  <= w_word;
      r_cnt    <= w_cnt_next;
    end else begin
      r_bitcnt <= r_bitcnt + 4'd1;
      r_shift  <= {1'b0, r_shift[9:1]};
    end
  end

  assign bus.tmdsSerialOut = r_shift[0];

endmodule

// File: tb/tb_encoder_serializer_core.sv
// Bench for encoder_serializer_core: word-level TMDS model checked against the serial stream every clock.
module tb_encoder_serializer_core;

  logic pixelClock = 1'b0;
  logic nReset     = 1'b1;
  always #5 pixelClock = ~pixelClock;

  encoder_serializer_core_if bus ();

  encoder_serializer_core dut (
    .pixelClock (pixelClock),
    .nReset     (nReset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // DVI 1.0 encoding rules on whole words with an integer disparity
  task automatic enc_model(input logic [7:0] d, input logic [1:0] c, input logic de,
                           input int ci, output logic [9:0] w, output int co);
    int n1, n1q, n0q;
    logic xn;
    logic [8:0] qm;
    if (!de) begin
      case (c)
        2'b00:   w = 10'b1101010100;
        2'b01:   w = 10'b0010101011;
        2'b10:   w = 10'b0101010100;
        default: w = 10'b1010101011;
      endcase
      co = 0;
    end else begin
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(d[i]);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1q = 0;
      for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
      n0q = 8 - n1q;
      if (ci == 0 || n1q == n0q) begin
        w  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        co = ci + (qm[8] ? (n1q - n0q) : (n0q - n1q));
      end else if ((ci > 0 && n1q > n0q) || (ci < 0 && n0q > n1q)) begin
        w  = {1'b1, qm[8], ~qm[7:0]};
        co = ci + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
        w  = {1'b0, qm[8], qm[7:0]};
        co = ci - (qm[8] ? 0 : 2) + n1q - n0q;
      end
    end
  endtask

  // Model: a word is taken every 10th clock after reset, bit 0 shown first
  int         m_edges  = 0;
  int         m_idx    = 0;
  int         m_cnt    = 0;
  logic       m_loaded = 1'b0;
  logic [9:0] m_word   = '0;

  always @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      m_edges = 0; m_idx = 0; m_cnt = 0; m_loaded = 1'b0; m_word = '0;
    end else begin
      m_edges++;
      if (m_edges % 10 == 0) begin
        enc_model(bus.pixelComponent, bus.controlBus, bus.DE, m_cnt, m_word, m_cnt);
        m_idx = 0;
        m_loaded = 1'b1;
      end else if (m_loaded) begin
        m_idx++;
      end
    end
  end

  always @(negedge pixelClock)
    chk("serial", 32'(bus.tmdsSerialOut), 32'(m_loaded ? m_word[m_idx] : 1'b0));

  task automatic wait_load(output int n);
    n = 0;
    do begin
      @(negedge pixelClock);
      n++;
    end while (!(m_loaded && m_idx == 0) && n < 40);
    if (n >= 40) chk("load_timeout", 32'(n), 32'd0);
  endtask

  task automatic cap(output logic [9:0] w);
    int n;
    wait_load(n);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge pixelClock);
      w[i] = bus.tmdsSerialOut;
    end
  endtask

  logic [9:0] tok_lit [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  initial begin
    logic [9:0] w;
    int c, n;
    bus.DE = 1'b0; bus.controlBus = 2'b00; bus.pixelComponent = 8'h00;
    #1 nReset = 1'b0;

    enc_model(8'h55, 2'b00, 1'b1, 0, w, c);  chk("m55_w", 32'(w), 32'h133); chk("m55_c", c, 0);
    enc_model(8'h00, 2'b00, 1'b1, 0, w, c);  chk("m00a_w", 32'(w), 32'h100); chk("m00a_c", c, -8);
    enc_model(8'h00, 2'b00, 1'b1, -8, w, c); chk("m00b_w", 32'(w), 32'h3FF); chk("m00b_c", c, 2);
    enc_model(8'h00, 2'b00, 1'b1, 2, w, c);  chk("m00c_w", 32'(w), 32'h100); chk("m00c_c", c, -6);
    enc_model(8'hA5, 2'b00, 1'b1, 0, w, c);  chk("mA5_w", 32'(w), 32'h163);
    enc_model(8'hFF, 2'b01, 1'b0, 5, w, c);  chk("mtok_w", 32'(w), 32'h0AB); chk("mtok_c", c, 0);

    repeat (3) @(negedge pixelClock);
    chk("rst_out", 32'(bus.tmdsSerialOut), 32'd0);
    nReset = 1'b1;

    cap(w); chk("tok00_a", 32'(w), 32'(tok_lit[0]));
    cap(w); chk("tok00_b", 32'(w), 32'(tok_lit[0]));
    for (int k = 1; k < 4; k++) begin
      bus.controlBus = 2'(k);
      cap(w); chk("tok_k", 32'(w), 32'(tok_lit[k]));
    end

    bus.DE = 1'b1; bus.pixelComponent = 8'h55;
    cap(w); chk("v55_a", 32'(w), 32'h133);
    cap(w); chk("v55_b", 32'(w), 32'h133);

    bus.DE = 1'b0; bus.controlBus = 2'b00;
    cap(w); chk("tok00_c", 32'(w), 32'(tok_lit[0]));
    bus.DE = 1'b1; bus.pixelComponent = 8'h00;
    cap(w); chk("v00_a", 32'(w), 32'h100);
    cap(w); chk("v00_b", 32'(w), 32'h3FF);
    cap(w); chk("v00_c", 32'(w), 32'h100);

    bus.DE = 1'b0; bus.controlBus = 2'b10;
    cap(w); chk("tok10_a", 32'(w), 32'(tok_lit[2]));
    wait_load(n);
    w[0] = bus.tmdsSerialOut;
    for (int i = 1; i < 10; i++) begin
      @(negedge pixelClock);
      w[i] = bus.tmdsSerialOut;
      if (i == 4) begin bus.DE = 1'b1; bus.pixelComponent = 8'hA5; end
    end
    chk("tok10_mid", 32'(w), 32'(tok_lit[2]));
    cap(w); chk("vA5", 32'(w), 32'h163);

    bus.pixelComponent = 8'h55;
    wait_load(n);
    repeat (3) @(negedge pixelClock);
    nReset = 1'b0;
    #1 chk("rst_async", 32'(bus.tmdsSerialOut), 32'd0);
    repeat (2) @(negedge pixelClock);
    nReset = 1'b1;
    wait_load(n);
    chk("first_load_lat", n, 10);
    chk("first_bit", 32'(bus.tmdsSerialOut), 32'd1);
    cap(w); chk("v55_rst", 32'(w), 32'h133);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
